// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_pkg.sv
// Shared types and helpers for the BIST one-hot encoder: FSM states,
// default widths and the saturating counter increment.
package arf054b128e1r1w0cbbehraa4acw_bist_pkg;

    localparam int IN_WIDTH_DEF  = 128;
    localparam int OUT_WIDTH_DEF = 7;
    localparam int CNT_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } bist_enc_state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt == max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_onehot_chk.sv
// Combinational one-hot checker: lowest-set-bit index plus zero-hot and
// multi-hot flags. No state; the parent registers everything.
module arf054b128e1r1w0cbbehraa4acw_bist_onehot_chk
    import arf054b128e1r1w0cbbehraa4acw_bist_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic [IN_WIDTH-1:0]  in_onehot,
    output logic [OUT_WIDTH-1:0] bin,
    output logic                 zero,
    output logic                 multi
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        bin = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (in_onehot[i]) begin
                bin = OUT_WIDTH'(i);
            end
        end
    end

    assign zero  = ~|in_onehot;
    // Clearing the lowest set bit leaves something only if more than one was set.
    assign multi = |(in_onehot & (in_onehot - IN_WIDTH'(1)));

endmodule

// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_encoder.sv
// BIST return-path one-hot to binary encoder with session FSM and verdict.
// Optional macro ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN adds err_cnt/first_err_idx.
module arf054b128e1r1w0cbbehraa4acw_bist_encoder
    import arf054b128e1r1w0cbbehraa4acw_bist_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 bist_start,
    input  logic                 bist_stop,
    input  logic                 in_vld,
    input  logic [IN_WIDTH-1:0]  in_onehot,
    output logic                 out_vld,
    output logic [OUT_WIDTH-1:0] out_bin,
    output logic                 out_err,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_fail,
`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] first_err_idx,
`endif
    output logic [CNT_WIDTH-1:0] smp_cnt
);

    if (IN_WIDTH != 2 ** OUT_WIDTH) begin : g_bad_width
        $error("IN_WIDTH must equal 2**OUT_WIDTH");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt
        $error("CNT_WIDTH must be in 1..32");
    end

    bist_enc_state_t      state_q, state_d;
    logic                 out_vld_q;
    logic [OUT_WIDTH-1:0] out_bin_q;
    logic                 out_err_q;
    logic                 fail_q, fail_d;
    logic [CNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d, smp_cnt_inc;

    logic [OUT_WIDTH-1:0] chk_bin;
    logic                 chk_zero, chk_multi, smp_err, run_smp;

    arf054b128e1r1w0cbbehraa4acw_bist_onehot_chk #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_chk (
        .in_onehot (in_onehot),
        .bin       (chk_bin),
        .zero      (chk_zero),
        .multi     (chk_multi)
    );

    assign smp_err     = chk_zero | chk_multi;
    // A restart takes priority over any sample arriving in the same cycle.
    assign run_smp     = (state_q == RUN) & in_vld & ~bist_start;
    assign smp_cnt_inc = CNT_WIDTH'(sat_inc(32'(smp_cnt_q), CNT_WIDTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (bist_stop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bist_start) begin
            state_d = RUN;
        end
    end

    always_comb begin
        smp_cnt_d = smp_cnt_q;
        fail_d    = fail_q;
        if (bist_start) begin
            smp_cnt_d = '0;
            fail_d    = 1'b0;
        end else if (run_smp) begin
            smp_cnt_d = smp_cnt_inc;
            fail_d    = fail_q | smp_err;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            out_vld_q <= 1'b0;
            out_bin_q <= '0;
            out_err_q <= 1'b0;
            fail_q    <= 1'b0;
            smp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= in_vld;
            out_err_q <= in_vld & smp_err;
            if (in_vld) begin
                out_bin_q <= chk_bin;
            end
            fail_q    <= fail_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] first_err_q, first_err_d;

    // The first failing sample is recognised by the verdict still being clear.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (bist_start) begin
            err_cnt_d   = '0;
            first_err_d = '0;
        end else if (run_smp & smp_err) begin
            err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CNT_WIDTH));
            if (!fail_q) begin
                first_err_d = smp_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
`endif

    assign out_vld   = out_vld_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;
    assign bist_busy = (state_q == RUN);
    assign bist_done = (state_q == DONE);
    assign bist_fail = fail_q;
    assign smp_cnt   = smp_cnt_q;

endmodule

// File: tb/tb_arf054b128e1r1w0cbbehraa4acw_bist_encoder.sv
// Scoreboard bench for the BIST one-hot encoder; honours
// ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN when defined.
module tb_arf054b128e1r1w0cbbehraa4acw_bist_encoder;

    localparam int CMAX = 255;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         bist_start = 1'b0;
    logic         bist_stop = 1'b0;
    logic         in_vld = 1'b0;
    logic [127:0] in_onehot = '0;
    logic         out_vld, out_err, bist_busy, bist_done, bist_fail;
    logic [6:0]   out_bin;
    logic [7:0]   smp_cnt;
`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
    logic [7:0]   err_cnt, first_err_idx;
`endif

    arf054b128e1r1w0cbbehraa4acw_bist_encoder dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .bist_start    (bist_start),
        .bist_stop     (bist_stop),
        .in_vld        (in_vld),
        .in_onehot     (in_onehot),
        .out_vld       (out_vld),
        .out_bin       (out_bin),
        .out_err       (out_err),
        .bist_busy     (bist_busy),
        .bist_done     (bist_done),
        .bist_fail     (bist_fail),
`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
`endif
        .smp_cnt       (smp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        bit err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_bin = 0;

    // Session reference: 0=idle, 1=running, 2=done
    int m_state = 0, m_cnt = 0, m_errcnt = 0, m_first = 0;
    bit m_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t ref_enc(input logic [127:0] d);
        exp_t e;
        bit found = 0;
        e.bin = 0;
        e.err = ($countones(d) != 1);
        for (int i = 0; i < 128; i++) begin
            if (!found && d[i]) begin
                e.bin = i;
                found = 1;
            end
        end
        return e;
    endfunction

    function automatic logic [127:0] rand_sample(input int kind);
        logic [127:0] d;
        d = '0;
        if (kind != 0) d[$urandom_range(127, 0)] = 1'b1;
        if (kind == 2) d[$urandom_range(127, 0)] = 1'b1;
        return d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_fail = 0; m_errcnt = 0; m_first = 0;
        last_bin = 0;
        q.delete();
    endtask

    task automatic check_session(input string tag);
        check({tag, ".busy"}, bist_busy, m_state == 1);
        check({tag, ".done"}, bist_done, m_state == 2);
        check({tag, ".fail"}, bist_fail, m_fail);
        check({tag, ".smp_cnt"}, smp_cnt, m_cnt);
`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
        check({tag, ".err_cnt"}, err_cnt, m_errcnt);
        check({tag, ".first_err_idx"}, first_err_idx, m_first);
`endif
    endtask

    task automatic cyc(input bit vld, input logic [127:0] d, input bit start, input bit stop);
        exp_t e;
        e = ref_enc(d);
        in_vld = vld; in_onehot = d; bist_start = start; bist_stop = stop;
        if (vld) q.push_back(e);
        if (start) begin
            m_state = 1; m_cnt = 0; m_fail = 0; m_errcnt = 0; m_first = 0;
        end else if (m_state == 1) begin
            if (vld) begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (e.err) begin
                    if (!m_fail) m_first = m_cnt;
                    m_fail = 1;
                    m_errcnt = (m_errcnt < CMAX) ? m_errcnt + 1 : CMAX;
                end
            end
            if (stop) m_state = 2;
        end else if (m_state == 2) begin
            m_state = 0;
        end
        @(posedge clk);
        #1;
        in_vld = 0; bist_start = 0; bist_stop = 0;
        check_session("cyc");
    endtask

    // Output monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        if (rst_b) begin
            if (out_vld) begin
                if (q.size() == 0) begin
                    check("unexpected_out_vld", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_bin", out_bin, e.bin);
                    check("out_err", out_err, e.err);
                    last_bin = e.bin;
                end
            end else begin
                check("out_err_idle", out_err, 0);
                check("out_bin_hold", out_bin, last_bin);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_vld", out_vld, 0);
        check("rst.out_bin", out_bin, 0);
        check("rst.out_err", out_err, 0);
        check_session("rst");
        rst_b = 1;
        model_reset();

        // Encoding outside a session
        cyc(1, 128'h1 << 77, 0, 0);
        cyc(1, 128'h1, 0, 0);
        cyc(1, 128'h1 << 127, 0, 0);
        cyc(1, (128'h1 << 5) | (128'h1 << 90), 0, 0);
        cyc(1, 128'h0, 0, 0);
        cyc(0, 128'h0, 0, 0);
        cyc(0, 128'h1 << 33, 0, 0);

        // Clean session of 10 samples
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, rand_sample(1), 0, 0);
        cyc(0, 0, 0, 1);
        check("t4.done", bist_done, 1);
        check("t4.smp_cnt", smp_cnt, 10);
        check("t4.fail", bist_fail, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t4.hold_cnt", smp_cnt, 10);
        check("t4.hold_done", bist_done, 0);

        // Saturating session with sample #3 zero-hot
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 300; i++) cyc(1, (i == 3) ? 128'h0 : rand_sample(1), 0, 0);
        cyc(0, 0, 0, 1);
        check("t5.smp_cnt", smp_cnt, 255);
        check("t5.fail", bist_fail, 1);
`ifdef ARF054B128E1R1W0CBBEHRAA4ACW_BIST_ENC_ERRCNT_EN
        check("t5.err_cnt", err_cnt, 1);
        check("t5.first_err_idx", first_err_idx, 3);
`endif

        // Start+stop together, then restart from DONE
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        check("t6.busy", bist_busy, 1);
        check("t6.no_done", bist_done, 0);
        cyc(1, rand_sample(2), 0, 0);
        cyc(0, 0, 0, 1);
        check("t6.done", bist_done, 1);
        cyc(0, 0, 1, 0);
        check("t6.restart_busy", bist_busy, 1);
        check("t6.restart_cnt", smp_cnt, 0);
        check("t6.restart_fail", bist_fail, 0);

        // Reset mid-session with the verdict set
        cyc(1, rand_sample(2), 0, 0);
        cyc(1, rand_sample(1), 0, 0);
        cyc(0, 0, 0, 0);
        check("t1.pre_fail", bist_fail, 1);
        #2;
        rst_b = 0;
        model_reset();
        #1;
        check("t1.async_busy", bist_busy, 0);
        check("t1.async_fail", bist_fail, 0);
        check("t1.async_cnt", smp_cnt, 0);
        check("t1.async_vld", out_vld, 0);
        @(posedge clk);
        #1;
        check("t1.no_done", bist_done, 0);
        check("t1.out_bin", out_bin, 0);
        check_session("t1");
        rst_b = 1;
        cyc(0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit st, sp, v;
            st = ($urandom_range(39, 0) == 0);
            sp = ($urandom_range(19, 0) == 0);
            v  = !st && ($urandom_range(3, 0) != 0);
            cyc(v, rand_sample($urandom_range(5, 0) < 4 ? 1 : $urandom_range(2, 0)), st, sp);
        end

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
